// File: rtl/axi4_stream_64b_16b_gbx_if.sv
// AXI4-Stream bundle with master/slave views; keep/strb width follows the data width.
interface axi4_stream_if #(
  parameter int DATA_W = 64,
  parameter int DEST_W = 1,
  parameter int ID_W   = 1,
  parameter int USER_W = 1
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;
  logic [USER_W-1:0]     tuser;
  logic [DEST_W-1:0]     tdest;
  logic [ID_W-1:0]       tid;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/axi4_stream_64b_16b_gbx.sv
// 64b -> 16b AXI4-Stream gearbox: holds one wide beat and emits its live 16b lanes in order,
// dropping lanes above the highest nonzero keep pair.
module axi4_stream_64b_16b_gbx #(
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TUSER_WIDTH = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  axi4_stream_if.slave   pkt_i,
  axi4_stream_if.master  pkt_o
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               pos_q, pos_d;
  logic [1:0]               last_lane_q, last_lane_d;
  logic [63:0]              beat_data_q, beat_data_d;
  logic [7:0]               beat_keep_q, beat_keep_d;
  logic [7:0]               beat_strb_q, beat_strb_d;
  logic                     beat_last_q, beat_last_d;
  logic                     tfirst_q, tfirst_d;
  logic [15:0]              out_data_q, out_data_d;
  logic [1:0]               out_keep_q, out_keep_d;
  logic [1:0]               out_strb_q, out_strb_d;
  logic                     out_last_q, out_last_d;
  logic [TUSER_WIDTH-1:0]   out_user_q, out_user_d;
  logic [TDEST_WIDTH-1:0]   out_dest_q, out_dest_d;
  logic [TID_WIDTH-1:0]     out_id_q, out_id_d;

  logic                     out_hs_s, at_end_s, in_ready_s, in_hs_s;
  logic [1:0]               nxt_pos_s, in_last_lane_s;

  function automatic logic [1:0] last_lane_f(input logic [7:0] keep);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (keep[2*k +: 2] != 2'b00) begin
        r = 2'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Handshake decode; tready depends only on held state and the sink, never on tvalid
  always_comb begin
    out_hs_s       = (state_q == HOLD) && pkt_o.tready;
    at_end_s       = (pos_q == last_lane_q);
    in_ready_s     = (state_q == EMPTY) || (out_hs_s && at_end_s);
    in_hs_s        = in_ready_s && pkt_i.tvalid;
    nxt_pos_s      = pos_q + 2'd1;
    in_last_lane_s = last_lane_f(pkt_i.tkeep);
  end

  // Next-state, lane pointer and registered output word
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    last_lane_d = last_lane_q;
    beat_data_d = beat_data_q;
    beat_keep_d = beat_keep_q;
    beat_strb_d = beat_strb_q;
    beat_last_d = beat_last_q;
    tfirst_d    = tfirst_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    out_dest_d  = out_dest_q;
    out_id_d    = out_id_q;
    if (in_hs_s) begin
      state_d     = HOLD;
      pos_d       = 2'd0;
      last_lane_d = in_last_lane_s;
      beat_data_d = pkt_i.tdata;
      beat_keep_d = pkt_i.tkeep;
      beat_strb_d = pkt_i.tstrb;
      beat_last_d = pkt_i.tlast;
      tfirst_d    = pkt_i.tlast;
      out_data_d  = pkt_i.tdata[15:0];
      out_keep_d  = pkt_i.tkeep[1:0];
      out_strb_d  = pkt_i.tstrb[1:0];
      out_last_d  = pkt_i.tlast && (in_last_lane_s == 2'd0);
      out_user_d  = tfirst_q ? pkt_i.tuser : {TUSER_WIDTH{1'b0}};
      out_dest_d  = pkt_i.tdest;
      out_id_d    = pkt_i.tid;
    end else if (out_hs_s) begin
      if (at_end_s) begin
        state_d = EMPTY;
      end else begin
        // Payload only advances on a handshake, so a stalled word stays put
        pos_d      = nxt_pos_s;
        out_data_d = beat_data_q[{nxt_pos_s, 4'b0000} +: 16];
        out_keep_d = beat_keep_q[{nxt_pos_s, 1'b0} +: 2];
        out_strb_d = beat_strb_q[{nxt_pos_s, 1'b0} +: 2];
        out_last_d = beat_last_q && (nxt_pos_s == last_lane_q);
        out_user_d = {TUSER_WIDTH{1'b0}};
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      pos_q       <= 2'd0;
      last_lane_q <= 2'd0;
      beat_data_q <= 64'd0;
      beat_keep_q <= 8'd0;
      beat_strb_q <= 8'd0;
      beat_last_q <= 1'b0;
      tfirst_q    <= 1'b1;
      out_data_q  <= 16'd0;
      out_keep_q  <= 2'd0;
      out_strb_q  <= 2'd0;
      out_last_q  <= 1'b0;
      out_user_q  <= {TUSER_WIDTH{1'b0}};
      out_dest_q  <= {TDEST_WIDTH{1'b0}};
      out_id_q    <= {TID_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      last_lane_q <= last_lane_d;
      beat_data_q <= beat_data_d;
      beat_keep_q <= beat_keep_d;
      beat_strb_q <= beat_strb_d;
      beat_last_q <= beat_last_d;
      tfirst_q    <= tfirst_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      out_dest_q  <= out_dest_d;
      out_id_q    <= out_id_d;
    end
  end

  assign pkt_i.tready = in_ready_s;
  assign pkt_o.tvalid = (state_q == HOLD);
  assign pkt_o.tdata  = out_data_q;
  assign pkt_o.tkeep  = out_keep_q;
  assign pkt_o.tstrb  = out_strb_q;
  assign pkt_o.tlast  = out_last_q;
  assign pkt_o.tuser  = out_user_q;
  assign pkt_o.tdest  = out_dest_q;
  assign pkt_o.tid    = out_id_q;

endmodule

// File: tb/tb_axi4_stream_64b_16b_gbx.sv
// Directed bench for the 64b->16b gearbox: hand-computed word sequences, handshake timing,
// stall stability, reset discard and partial-keep lane dropping.
module tb_axi4_stream_64b_16b_gbx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(64), .DEST_W(2), .ID_W(3), .USER_W(1)) in_if ();
  axi4_stream_if #(.DATA_W(16), .DEST_W(2), .ID_W(3), .USER_W(1)) out_if ();

  axi4_stream_64b_16b_gbx #(.TDEST_WIDTH(2), .TID_WIDTH(3), .TUSER_WIDTH(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pkt_i (in_if),
    .pkt_o (out_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink: 0 = never ready, 1 = always ready, other = toggle every cycle
  int   sink_mode = 0;
  logic sink_rdy  = 1'b0;
  always @(negedge clk) begin
    case (sink_mode)
      0:       sink_rdy = 1'b0;
      1:       sink_rdy = 1'b1;
      default: sink_rdy = ~sink_rdy;
    endcase
  end
  assign out_if.tready = sink_rdy;

  // Handshake log and stall-stability monitor
  int          cyc = 0;
  logic [15:0] q_data[$];
  logic [1:0]  q_keep[$];
  logic        q_last[$];
  logic        q_user[$];
  logic [1:0]  q_dest[$];
  logic [2:0]  q_id[$];
  int          q_cyc[$];
  int          i_cyc[$];
  logic        prev_stall = 1'b0;
  logic [20:0] prev_pl;
  logic [20:0] cur_pl;
  always @(posedge clk) begin
    cur_pl = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser, out_if.tstrb[0]};
    if (!rst && out_if.tvalid && out_if.tready) begin
      q_data.push_back(out_if.tdata);
      q_keep.push_back(out_if.tkeep);
      q_last.push_back(out_if.tlast);
      q_user.push_back(out_if.tuser);
      q_dest.push_back(out_if.tdest);
      q_id.push_back(out_if.tid);
      q_cyc.push_back(cyc);
    end
    if (!rst && in_if.tvalid && in_if.tready) i_cyc.push_back(cyc);
    if (prev_stall && out_if.tvalid) check_val("stall_stable", 64'(cur_pl), 64'(prev_pl));
    prev_stall = !rst && out_if.tvalid && !out_if.tready;
    prev_pl    = cur_pl;
    cyc = cyc + 1;
  end

  task automatic check_word(input string tag, input int idx, input logic [15:0] d,
                            input logic [1:0] k, input logic l, input logic u);
    if (idx < q_data.size())
      check_val($sformatf("%s[%0d]", tag, idx), {q_data[idx], q_keep[idx], q_last[idx], q_user[idx]},
                {d, k, l, u});
    else
      check_val($sformatf("%s[%0d]_missing", tag, idx), 64'(q_data.size()), 64'(idx + 1));
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u, input logic [1:0] de, input logic [2:0] id);
    int n;
    @(negedge clk);
    in_if.tvalid = 1'b1; in_if.tdata = d; in_if.tkeep = k; in_if.tstrb = k;
    in_if.tlast = l; in_if.tuser = u; in_if.tdest = de; in_if.tid = id;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_if.tready && n < 60);
    if (!in_if.tready) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_drain(input int n);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] lw(input logic [3:0] t, input int j, input int k);
    return {t, 4'(j), 4'h0, 4'(k)};
  endfunction

  function automatic logic [63:0] beat_of(input logic [3:0] t, input int j);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[16*k +: 16] = lw(t, j, k);
    return d;
  endfunction

  int b, ib, b0, n;

  initial begin
    rst = 1'b1;
    in_if.tvalid = 1'b0; in_if.tdata = 64'd0; in_if.tkeep = 8'd0; in_if.tstrb = 8'd0;
    in_if.tlast = 1'b0; in_if.tuser = 1'b0; in_if.tdest = 2'd0; in_if.tid = 3'd0;
    repeat (3) @(negedge clk);
    check_val("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check_val("rst_payload", {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast, out_if.tuser},
              64'd0);
    check_val("rst_dest_id", {out_if.tdest, out_if.tid}, 64'd0);
    check_val("rst_tready", 64'(in_if.tready), 64'd1);
    rst = 1'b0;
    #1 sink_mode = 1;

    // Single full beat, sink always ready
    b = q_data.size();
    send_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1, 2'd2, 3'd5);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    check_val("t1_tvalid", 64'(out_if.tvalid), 64'd1);
    check_val("t1_rdy_low0", 64'(in_if.tready), 64'd0);
    @(negedge clk);
    check_val("t1_rdy_low1", 64'(in_if.tready), 64'd0);
    @(negedge clk);
    check_val("t1_rdy_low2", 64'(in_if.tready), 64'd0);
    @(negedge clk);
    check_val("t1_rdy_high", 64'(in_if.tready), 64'd1);
    repeat (2) @(negedge clk);
    check_val("t1_tvalid_end", 64'(out_if.tvalid), 64'd0);
    check_word("t1_w", b + 0, 16'h1111, 2'b11, 1'b0, 1'b1);
    check_word("t1_w", b + 1, 16'h2222, 2'b11, 1'b0, 1'b0);
    check_word("t1_w", b + 2, 16'h3333, 2'b11, 1'b0, 1'b0);
    check_word("t1_w", b + 3, 16'h4444, 2'b11, 1'b1, 1'b0);
    if (q_data.size() >= b + 4) begin
      check_val("t1_dest_id", {q_dest[b+3], q_id[b+3]}, {2'd2, 3'd5});
      check_val("t1_consecutive", 64'(q_cyc[b+3] - q_cyc[b]), 64'd3);
    end else check_val("t1_count", 64'(q_data.size() - b), 64'd4);

    // Back-to-back full beats, tvalid held high
    b = q_data.size(); ib = i_cyc.size();
    for (int j = 0; j < 3; j++) send_beat(beat_of(4'hA, j), 8'hFF, j == 2, j == 0, 2'd1, 3'd2);
    idle_drain(8);
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 4; k++)
        check_word("t2_w", b + 4*j + k, lw(4'hA, j, k), 2'b11, (j == 2 && k == 3), (j == 0 && k == 0));
    if (q_data.size() >= b + 12 && i_cyc.size() >= ib + 3) begin
      check_val("t2_no_bubble", 64'(q_cyc[b+11] - q_cyc[b]), 64'd11);
      check_val("t2_in_gap0", 64'(i_cyc[ib+1] - i_cyc[ib]), 64'd4);
      check_val("t2_in_gap1", 64'(i_cyc[ib+2] - i_cyc[ib+1]), 64'd4);
    end else check_val("t2_count", 64'(q_data.size() - b), 64'd12);

    // Half beat (keep 0F) then a full beat accepted on the final half-beat handshake
    b = q_data.size(); ib = i_cyc.size();
    send_beat(64'hBBB4_BBB3_BBB2_BBB1, 8'h0F, 1'b1, 1'b1, 2'd3, 3'd7);
    send_beat(64'hC004_C003_C002_C001, 8'hFF, 1'b1, 1'b1, 2'd0, 3'd1);
    idle_drain(8);
    check_word("t3_w", b + 0, 16'hBBB1, 2'b11, 1'b0, 1'b1);
    check_word("t3_w", b + 1, 16'hBBB2, 2'b11, 1'b1, 1'b0);
    check_word("t3_w", b + 2, 16'hC001, 2'b11, 1'b0, 1'b1);
    check_word("t3_w", b + 5, 16'hC004, 2'b11, 1'b1, 1'b0);
    if (q_data.size() >= b + 6 && i_cyc.size() >= ib + 2) begin
      check_val("t3_accept_same_cycle", 64'(i_cyc[ib+1]), 64'(q_cyc[b+1]));
      check_val("t3_count", 64'(q_data.size() - b), 64'd6);
    end else check_val("t3_count", 64'(q_data.size() - b), 64'd6);

    // Toggling sink over a 3-beat packet
    #1 sink_mode = 2;
    b = q_data.size();
    for (int j = 0; j < 3; j++) send_beat(beat_of(4'hD, j), 8'hFF, j == 2, j == 0, 2'd2, 3'd3);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    n = 0;
    while (q_data.size() < b + 12 && n < 80) begin
      @(negedge clk);
      n++;
    end
    #1 sink_mode = 1;
    for (int w = 0; w < 12; w++)
      check_word("t4_w", b + w, lw(4'hD, w / 4, w % 4), 2'b11, w == 11, w == 0);

    // Reset while lane 1 is held
    repeat (2) @(negedge clk);
    b0 = q_data.size();
    send_beat(beat_of(4'hE, 0), 8'hFF, 1'b1, 1'b1, 2'd1, 3'd1);
    @(posedge clk);
    sink_mode = 0;
    @(negedge clk);
    in_if.tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check_val("t5_rst_tready", 64'(in_if.tready), 64'd1);
    check_val("t5_rst_tdata", 64'(out_if.tdata), 64'd0);
    rst = 1'b0;
    #1 sink_mode = 1;
    check_val("t5_words_before_rst", 64'(q_data.size() - b0), 64'd1);
    b = q_data.size();
    send_beat(beat_of(4'hF, 0), 8'hFF, 1'b1, 1'b1, 2'd0, 3'd0);
    idle_drain(8);
    check_word("t5_w", b + 0, lw(4'hF, 0, 0), 2'b11, 1'b0, 1'b1);
    check_word("t5_w", b + 3, lw(4'hF, 0, 3), 2'b11, 1'b1, 1'b0);
    check_val("t5_count", 64'(q_data.size() - b), 64'd4);

    // Partial / empty keep: 00 tlast, 03 non-tlast, 30 tlast with tuser while tfirst clear
    b = q_data.size();
    send_beat(64'h9999_8888_7777_1234, 8'h00, 1'b1, 1'b0, 2'd0, 3'd0);
    send_beat(64'h9999_8888_7777_5678, 8'h03, 1'b0, 1'b0, 2'd0, 3'd0);
    send_beat(64'h7773_7772_7771_7770, 8'h30, 1'b1, 1'b1, 2'd0, 3'd0);
    idle_drain(8);
    check_word("t6_w", b + 0, 16'h1234, 2'b00, 1'b1, 1'b0);
    check_word("t6_w", b + 1, 16'h5678, 2'b11, 1'b0, 1'b0);
    check_word("t6_w", b + 2, 16'h7770, 2'b00, 1'b0, 1'b0);
    check_word("t6_w", b + 3, 16'h7771, 2'b00, 1'b0, 1'b0);
    check_word("t6_w", b + 4, 16'h7772, 2'b11, 1'b1, 1'b0);
    check_val("t6_count", 64'(q_data.size() - b), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
